// File: rtl/mult_lut_sequencer.sv
// Multi-cycle unsigned WIDTH x WIDTH multiplier that time-shares one external
// combinational 4x4 LUT multiplier, accumulating shifted digit-pair products.
module mult_lut_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               io_in_valid,
   output logic               io_in_ready,
   input  logic [WIDTH-1:0]   io_in_lhs,
   input  logic [WIDTH-1:0]   io_in_rhs,
   output logic               io_out_valid,
   input  logic               io_out_ready,
   output logic [2*WIDTH-1:0] io_out_data,
   output logic [3:0]         io_lut_lhs,
   output logic [3:0]         io_lut_rhs,
   input  logic [7:0]         io_lut_out,
   output logic               io_busy
);

   localparam int N  = WIDTH / 4;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int AW = 2 * WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  lhs_q, lhs_d, rhs_q, rhs_d;
   logic [AW-1:0]     acc_q, acc_d, out_data_q, out_data_d;
   logic [IW-1:0]     i_q, i_d, j_q, j_d;
   logic              out_valid_q, out_valid_d;
   logic [AW-1:0]     pp_ext, acc_sum;

   // LUT address is quiescent (zero) outside RUN.
   always_comb begin
      io_lut_lhs = '0;
      io_lut_rhs = '0;
      if (state_q == RUN) begin
         io_lut_lhs = lhs_q[4*i_q +: 4];
         io_lut_rhs = rhs_q[4*j_q +: 4];
      end
   end

   always_comb begin
      pp_ext  = AW'(io_lut_out);
      acc_sum = acc_q + (pp_ext << (4 * (int'(i_q) + int'(j_q))));
   end

   always_comb begin
      state_d     = state_q;
      lhs_d       = lhs_q;
      rhs_d       = rhs_q;
      acc_d       = acc_q;
      i_d         = i_q;
      j_d         = j_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (io_in_valid) begin
               lhs_d   = io_in_lhs;
               rhs_d   = io_in_rhs;
               acc_d   = '0;
               i_d     = '0;
               j_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = acc_sum;
            if (j_q == IW'(N - 1)) begin
               j_d = '0;
               if (i_q == IW'(N - 1)) begin
                  // Last pair: the product is final this cycle.
                  i_d         = '0;
                  out_data_d  = acc_sum;
                  out_valid_d = 1'b1;
                  state_d     = DONE;
               end else begin
                  i_d = i_q + 1'b1;
               end
            end else begin
               j_d = j_q + 1'b1;
            end
         end
         DONE: begin
            if (io_out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         lhs_q       <= '0;
         rhs_q       <= '0;
         acc_q       <= '0;
         i_q         <= '0;
         j_q         <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lhs_q       <= lhs_d;
         rhs_q       <= rhs_d;
         acc_q       <= acc_d;
         i_q         <= i_d;
         j_q         <= j_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign io_in_ready  = (state_q == IDLE);
   assign io_busy      = (state_q == RUN) || (state_q == DONE);
   assign io_out_valid = out_valid_q;
   assign io_out_data  = out_data_q;

endmodule
